// File: rtl/stopwatch_ctrl.sv
// Stopwatch controller: IDLE/RUN/PAUSE/LAP sequencing, tick prescaler and a
// BCD mm:ss.cc count with a lap-hold display register.

module sw_bcd_digit #(
  parameter logic [3:0] MAX = 4'd9
) (
  input  logic [3:0] q,
  input  logic       inc,
  output logic       at_max,
  output logic [3:0] nxt
);
  // ">=" rather than "==" so a corrupted digit still snaps back into range.
  always_comb begin
    at_max = (q >= MAX);
    nxt    = q;
    if (inc) nxt = at_max ? 4'd0 : q + 4'd1;
  end
endmodule

module stopwatch_ctrl #(
  parameter int CLK_HZ  = 100_000_000,
  parameter int TICK_HZ = 100
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ss_p,
  input  logic       lap_p,
  input  logic       clr_p,
  output logic       running,
  output logic       frozen,
  output logic [3:0] d_min_t,
  output logic [3:0] d_min_u,
  output logic [3:0] d_sec_t,
  output logic [3:0] d_sec_u,
  output logic [3:0] d_cs_t,
  output logic [3:0] d_cs_u,
  output logic       wrap_p
);
  localparam int DIV    = CLK_HZ / TICK_HZ;
  localparam int PW     = $clog2(DIV);
  localparam int NDIG   = 6;
  localparam logic [PW-1:0] PRE_LAST = PW'(DIV - 1);

  // bit 0 of the encoding doubles as "running" (RUN and LAP both odd)
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_PAUSE = 2'd2;
  localparam logic [1:0] S_LAP   = 2'd3;

  // digit order: [0]=cs_u [1]=cs_t [2]=sec_u [3]=sec_t [4]=min_u [5]=min_t
  localparam logic [NDIG-1:0][3:0] DMAX = {4'd5, 4'd9, 4'd5, 4'd9, 4'd9, 4'd9};

  logic [1:0]            state, state_nxt;
  logic [PW-1:0]         pre;
  logic [NDIG-1:0][3:0]  cnt, cnt_nxt, lap_q, disp;
  logic [NDIG-1:0]       inc, at_max;
  logic                  active, tick, lap_cap, clr_all, wrap;

  assign active = state[0];
  assign tick   = active && (pre == PRE_LAST);

  always_comb begin
    inc[0] = tick;
    for (int i = 1; i < NDIG; i++) inc[i] = inc[i-1] && at_max[i-1];
  end

  assign wrap = inc[NDIG-1] && at_max[NDIG-1];

  for (genvar i = 0; i < NDIG; i++) begin : g_dig
    sw_bcd_digit #(.MAX(DMAX[i])) u_dig (
      .q      (cnt[i]),
      .inc    (inc[i]),
      .at_max (at_max[i]),
      .nxt    (cnt_nxt[i])
    );
  end

  // Only the highest-priority request that is meaningful in the current
  // state acts; clear is only honoured from PAUSE.
  always_comb begin
    state_nxt = state;
    lap_cap   = 1'b0;
    clr_all   = 1'b0;
    case (state)
      S_IDLE:  if (ss_p) state_nxt = S_RUN;
      S_RUN: begin
        if (ss_p) state_nxt = S_PAUSE;
        else if (lap_p) begin
          state_nxt = S_LAP;
          lap_cap   = 1'b1;
        end
      end
      S_LAP: begin
        if (ss_p)       state_nxt = S_PAUSE;
        else if (lap_p) state_nxt = S_RUN;
      end
      S_PAUSE: begin
        if (clr_p) begin
          state_nxt = S_IDLE;
          clr_all   = 1'b1;
        end else if (ss_p) state_nxt = S_RUN;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      pre    <= '0;
      cnt    <= '0;
      lap_q  <= '0;
      wrap_p <= 1'b0;
    end else begin
      state  <= state_nxt;
      wrap_p <= wrap;
      if (clr_all)     pre <= '0;
      else if (tick)   pre <= '0;
      else if (active) pre <= pre + PW'(1);
      cnt <= clr_all ? '0 : cnt_nxt;
      // capture the pre-increment count, even on a tick edge
      if (clr_all)      lap_q <= '0;
      else if (lap_cap) lap_q <= cnt;
    end
  end

  assign running = state[0];
  assign frozen  = (state == S_LAP);
  assign disp    = frozen ? lap_q : cnt;

  assign d_min_t = disp[5];
  assign d_min_u = disp[4];
  assign d_sec_t = disp[3];
  assign d_sec_u = disp[2];
  assign d_cs_t  = disp[1];
  assign d_cs_u  = disp[0];
endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Bench for stopwatch_ctrl: directed table, hand sequences for the timing
// corners, and random pulses against a centisecond-integer reference model.

module tb_stopwatch_ctrl;
  localparam int CLK_HZ  = 1000;
  localparam int TICK_HZ = 100;
  localparam int DIV     = CLK_HZ / TICK_HZ;
  localparam int WRAPC   = 60 * 60 * 100;

  logic clk = 1'b0, rst_n = 1'b0, ss_p = 1'b0, lap_p = 1'b0, clr_p = 1'b0;
  logic running, frozen, wrap_p;
  logic [3:0] d_min_t, d_min_u, d_sec_t, d_sec_u, d_cs_t, d_cs_u;

  always #5 clk = ~clk;

  stopwatch_ctrl #(.CLK_HZ(CLK_HZ), .TICK_HZ(TICK_HZ)) dut (
    .clk(clk), .rst_n(rst_n), .ss_p(ss_p), .lap_p(lap_p), .clr_p(clr_p),
    .running(running), .frozen(frozen),
    .d_min_t(d_min_t), .d_min_u(d_min_u), .d_sec_t(d_sec_t),
    .d_sec_u(d_sec_u), .d_cs_t(d_cs_t), .d_cs_u(d_cs_u), .wrap_p(wrap_p)
  );

  int n_cmp = 0, n_err = 0;

  // reference: state 0 idle, 1 run, 2 pause, 3 lap; count in centiseconds
  int m_st, m_cnt, m_lap, m_pre;
  bit m_wrap;

  function automatic logic [23:0] to_bcd(input int c);
    int mn, sc, cs;
    mn = c / 6000; sc = (c / 100) % 60; cs = c % 100;
    return {4'(mn / 10), 4'(mn % 10), 4'(sc / 10), 4'(sc % 10), 4'(cs / 10), 4'(cs % 10)};
  endfunction

  function int dut_cs();
    return ((d_min_t * 10 + d_min_u) * 60 + d_sec_t * 10 + d_sec_u) * 100
           + d_cs_t * 10 + d_cs_u;
  endfunction

  function logic [31:0] outs();
    return {5'b0, running, frozen, wrap_p, d_min_t, d_min_u, d_sec_t, d_sec_u, d_cs_t, d_cs_u};
  endfunction

  function logic [31:0] model_outs();
    bit r, f;
    r = (m_st == 1) || (m_st == 3);
    f = (m_st == 3);
    return {5'b0, r, f, m_wrap, to_bcd(f ? m_lap : m_cnt)};
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      if (n_err <= 40) $display("FAIL %s: actual 0x%0h required 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_st = 0; m_cnt = 0; m_lap = 0; m_pre = 0; m_wrap = 0;
  endtask

  task automatic model_step(input bit s, input bit l, input bit c);
    bit act, tick;
    act    = (m_st == 1) || (m_st == 3);
    tick   = act && (m_pre == DIV - 1);
    m_wrap = tick && (m_cnt == WRAPC - 1);
    case (m_st)
      0: if (s) m_st = 1;
      1: if (s) m_st = 2; else if (l) begin m_st = 3; m_lap = m_cnt; end
      3: if (s) m_st = 2; else if (l) m_st = 1;
      2: if (c) begin m_st = 0; m_cnt = 0; m_lap = 0; m_pre = 0; end
         else if (s) m_st = 1;
      default: m_st = 0;
    endcase
    if (tick)     m_cnt = (m_cnt + 1) % WRAPC;
    if (tick)     m_pre = 0;
    else if (act) m_pre = m_pre + 1;
  endtask

  task automatic cyc(input bit s, input bit l, input bit c);
    ss_p = s; lap_p = l; clr_p = c;
    @(posedge clk);
    model_step(s, l, c);
    #1;
    ss_p = 0; lap_p = 0; clr_p = 0;
    check("cycle_vs_model", outs(), model_outs());
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    model_reset();
    #1;
    check("reset_state", outs(), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  typedef struct {
    bit s, l, c;
    bit er, ef, ez;
  } vec_t;
  vec_t tbl[15];

  initial begin
    int n_wrap, held, n, seen_zero, all_run, changed;

    tbl[0]  = '{0,1,0, 0,0,1};  // IDLE: lap ignored
    tbl[1]  = '{0,0,1, 0,0,1};  // IDLE: clear ignored
    tbl[2]  = '{1,0,0, 1,0,0};  // -> RUN
    tbl[3]  = '{0,1,0, 1,1,0};  // -> LAP
    tbl[4]  = '{0,0,1, 1,1,0};  // LAP: clear ignored
    tbl[5]  = '{0,1,0, 1,0,0};  // -> RUN
    tbl[6]  = '{0,1,0, 1,1,0};  // -> LAP
    tbl[7]  = '{1,0,0, 0,0,0};  // -> PAUSE
    tbl[8]  = '{0,1,0, 0,0,0};  // PAUSE: lap ignored
    tbl[9]  = '{1,0,0, 1,0,0};  // -> RUN
    tbl[10] = '{1,1,1, 0,0,0};  // RUN triple: ss wins -> PAUSE
    tbl[11] = '{1,1,1, 0,0,1};  // PAUSE triple: clear wins -> IDLE
    tbl[12] = '{1,1,0, 1,0,0};  // IDLE: ss -> RUN
    tbl[13] = '{1,1,0, 0,0,0};  // RUN: ss beats lap -> PAUSE
    tbl[14] = '{0,0,1, 0,0,1};  // -> IDLE, zeroed

    do_reset();
    for (int i = 0; i < 15; i++) begin
      cyc(tbl[i].s, tbl[i].l, tbl[i].c);
      for (int k = 0; k < 8; k++) cyc(0, 0, 0);
      check($sformatf("tbl%0d_running", i), 32'(running), 32'(tbl[i].er));
      check($sformatf("tbl%0d_frozen", i), 32'(frozen), 32'(tbl[i].ef));
      if (tbl[i].ez) check($sformatf("tbl%0d_zero", i), 32'(dut_cs()), 32'd0);
    end

    // one second of counting
    do_reset();
    cyc(1, 0, 0);
    n_wrap = 0;
    for (int k = 0; k < 1000; k++) begin
      cyc(0, 0, 0);
      if (wrap_p) n_wrap++;
    end
    check("one_sec_running", 32'(running), 32'd1);
    check("one_sec_range", 32'(dut_cs() >= 99 && dut_cs() <= 101), 32'd1);
    check("one_sec_nowrap", 32'(n_wrap), 32'd0);

    // lap hold and release
    do_reset();
    cyc(1, 0, 0);
    for (int k = 0; k < 2000 && m_cnt != 42; k++) cyc(0, 0, 0);
    check("reach_42", 32'(dut_cs()), 32'd42);
    cyc(0, 1, 0);
    check("lap_frozen", 32'(frozen), 32'd1);
    check("lap_show", 32'(dut_cs()), 32'd42);
    for (int k = 0; k < 199; k++) cyc(0, 0, 0);
    check("lap_hold", 32'(dut_cs()), 32'd42);
    cyc(0, 1, 0);
    check("lap_release_frozen", 32'(frozen), 32'd0);
    check("lap_release_live", 32'(dut_cs() >= 61 && dut_cs() <= 63), 32'd1);

    // wrap from 59:59.98, preloaded while paused
    do_reset();
    cyc(1, 0, 0);
    cyc(1, 0, 0);
    @(negedge clk);
    force dut.cnt = 24'h595998;
    #1;
    release dut.cnt;
    m_cnt = WRAPC - 2;
    check("preload", 32'(dut_cs()), 32'(WRAPC - 2));
    cyc(1, 0, 0);
    n_wrap = 0; seen_zero = 0; all_run = 1;
    for (int k = 0; k < 30; k++) begin
      cyc(0, 0, 0);
      if (!running) all_run = 0;
      if (wrap_p) begin
        n_wrap++;
        if (dut_cs() == 0) seen_zero = 1;
      end
    end
    check("wrap_once", 32'(n_wrap), 32'd1);
    check("wrap_at_zero", 32'(seen_zero), 32'd1);
    check("wrap_running", 32'(all_run), 32'd1);
    check("wrap_after", 32'(dut_cs()), 32'd1);

    // pause mid-prescale, resume finishes the partial period
    do_reset();
    cyc(1, 0, 0);
    for (int k = 0; k < 500 && !(m_cnt == 5 && m_pre == 4); k++) cyc(0, 0, 0);
    cyc(1, 0, 0);
    held = dut_cs();
    changed = 0;
    for (int k = 0; k < 500; k++) begin
      cyc(0, 0, 0);
      if (dut_cs() != held) changed = 1;
    end
    check("pause_value", 32'(held), 32'd5);
    check("pause_hold", 32'(changed), 32'd0);
    cyc(1, 0, 0);
    n = 0;
    for (int k = 0; k < 20 && dut_cs() == 5; k++) begin
      cyc(0, 0, 0);
      n++;
    end
    check("resume_gap", 32'(n), 32'd5);

    // asynchronous reset during LAP, then ignored requests in IDLE
    do_reset();
    cyc(1, 0, 0);
    for (int k = 0; k < 37; k++) cyc(0, 0, 0);
    cyc(0, 1, 0);
    for (int k = 0; k < 3; k++) cyc(0, 0, 0);
    check("pre_rst_frozen", 32'(frozen), 32'd1);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check("async_rst", outs(), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc(0, 0, 1);
    cyc(0, 1, 0);
    check("idle_ignore", outs(), 32'h0);

    // random pulses against the reference model
    do_reset();
    for (int k = 0; k < 4000; k++)
      cyc($urandom_range(0, 15) == 0, $urandom_range(0, 11) == 0, $urandom_range(0, 19) == 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
